// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: MEM-stage FSM encoding and control-bundle layout shared with the hazard/forwarding unit.
package mem_stage_pkg;
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} mem_state_e;
  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
  } ctrl_t;
endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register; bubble_i clears the control bits so WB never writes twice.
module mem_wb_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bubble_i,
  input  logic              valid_i,
  input  logic              reg_write_i,
  input  logic              mem_to_reg_i,
  input  logic [DATA_W-1:0] read_data_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [REG_W-1:0]  reg_dest_i,
  output logic              valid_o,
  output logic              reg_write_o,
  output logic              mem_to_reg_o,
  output logic [DATA_W-1:0] read_data_o,
  output logic [DATA_W-1:0] alu_result_o,
  output logic [REG_W-1:0]  reg_dest_o
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_o      <= 1'b0;
      reg_write_o  <= 1'b0;
      mem_to_reg_o <= 1'b0;
      read_data_o  <= '0;
      alu_result_o <= '0;
      reg_dest_o   <= '0;
    end else begin
      valid_o      <= valid_i & ~bubble_i;
      reg_write_o  <= reg_write_i & ~bubble_i;
      mem_to_reg_o <= mem_to_reg_i & ~bubble_i;
      read_data_o  <= read_data_i;
      alu_result_o <= alu_result_i;
      reg_dest_o   <= reg_dest_i;
    end
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM register, branch resolve and data-memory access FSM with timeout abort.
module mem_stage import mem_stage_pkg::*; #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ALUresult,
  input  logic [DATA_W-1:0] EX_Rt,
  input  logic [REG_W-1:0]  RegDest,
  input  logic              zero,
  input  logic [DATA_W-1:0] Branch_Addr,
  input  logic              Branch,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic              flush,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic              PCSrc,
  output logic [DATA_W-1:0] PCBranch,
  output logic [DATA_W-1:0] EXtoMEM_ALUresult,
  output logic              EXtoMEM_RegWrite,
  output logic [REG_W-1:0]  EXtoMEM_RegDest,
  output logic              wb_valid,
  output logic              wb_RegWrite,
  output logic              wb_MemtoReg,
  output logic [DATA_W-1:0] wb_ReadData,
  output logic [DATA_W-1:0] wb_ALUresult,
  output logic [REG_W-1:0]  wb_RegDest,
  output logic              mem_fault
);
  localparam int CNT_W = $clog2(TIMEOUT);
  logic              m_valid_q, m_zero_q;
  ctrl_t             m_ctrl_q, ex_ctrl;
  logic [DATA_W-1:0] m_alu_q, m_rt_q, m_baddr_q;
  logic [REG_W-1:0]  m_rd_q;
  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              live, is_mem, misaligned, abort;
  always_comb begin
    live       = ex_valid & ~flush;
    ex_ctrl    = '{branch: Branch, mem_read: MemRead, mem_write: MemWrite, mem_to_reg: MemtoReg, reg_write: RegWrite};
    is_mem     = m_valid_q & (m_ctrl_q.mem_read | m_ctrl_q.mem_write);
    misaligned = is_mem & |m_alu_q[1:0];
    // abort in the cycle the counter would reach TIMEOUT-1, so stall lasts TIMEOUT-1 cycles
    abort      = state_q == ACCESS & ~dmem_ready & cnt_q == CNT_W'(TIMEOUT - 2);
    dmem_req   = is_mem & ~misaligned & ~abort;
    stall      = dmem_req & ~dmem_ready;
    state_d    = stall ? ACCESS : IDLE;
    cnt_d      = (state_q == ACCESS & stall) ? cnt_q + 1'b1 : '0;
    dmem_we    = dmem_req & m_ctrl_q.mem_write;
    dmem_addr  = dmem_req ? m_alu_q : '0;
    dmem_wdata = dmem_we ? m_rt_q : '0;
    mem_fault  = misaligned | abort;
    PCSrc      = m_valid_q & m_ctrl_q.branch & m_zero_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_ctrl_q  <= '0;
      m_zero_q  <= 1'b0;
      m_alu_q   <= '0;
      m_rt_q    <= '0;
      m_baddr_q <= '0;
      m_rd_q    <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!stall) begin
        m_valid_q <= live;
        m_ctrl_q  <= live ? ex_ctrl : '0;
        m_zero_q  <= zero;
        m_alu_q   <= ALUresult;
        m_rt_q    <= EX_Rt;
        m_baddr_q <= Branch_Addr;
        m_rd_q    <= RegDest;
      end
    end
  end
  assign PCBranch          = m_baddr_q;
  assign EXtoMEM_ALUresult = m_alu_q;
  assign EXtoMEM_RegWrite  = m_ctrl_q.reg_write;
  assign EXtoMEM_RegDest   = m_rd_q;
  mem_wb_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) u_mem_wb (
    .clk          (clk),
    .reset        (reset),
    .bubble_i     (stall),
    .valid_i      (m_valid_q),
    .reg_write_i  (m_ctrl_q.reg_write & ~mem_fault),
    .mem_to_reg_i (m_ctrl_q.mem_to_reg),
    .read_data_i  (dmem_rdata),
    .alu_result_i (m_alu_q),
    .reg_dest_i   (m_rd_q),
    .valid_o      (wb_valid),
    .reg_write_o  (wb_RegWrite),
    .mem_to_reg_o (wb_MemtoReg),
    .read_data_o  (wb_ReadData),
    .alu_result_o (wb_ALUresult),
    .reg_dest_o   (wb_RegDest)
  );
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table plus stall, timeout and mid-access reset sequences for mem_stage.
module tb_mem_stage;
  logic        clk = 1'b0, reset = 1'b1;
  logic        ex_valid, zero, Branch, MemRead, MemWrite, MemtoReg, RegWrite, flush, dmem_ready;
  logic [31:0] ALUresult, EX_Rt, Branch_Addr, dmem_rdata;
  logic [4:0]  RegDest;
  logic        dmem_req, dmem_we, stall, PCSrc, EXtoMEM_RegWrite, wb_valid, wb_RegWrite, wb_MemtoReg, mem_fault;
  logic [31:0] dmem_addr, dmem_wdata, PCBranch, EXtoMEM_ALUresult, wb_ReadData, wb_ALUresult;
  logic [4:0]  EXtoMEM_RegDest, wb_RegDest;
  int n_chk = 0, n_err = 0;

  mem_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ALUresult(ALUresult), .EX_Rt(EX_Rt),
    .RegDest(RegDest), .zero(zero), .Branch_Addr(Branch_Addr), .Branch(Branch), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .flush(flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .stall(stall), .PCSrc(PCSrc), .PCBranch(PCBranch),
    .EXtoMEM_ALUresult(EXtoMEM_ALUresult), .EXtoMEM_RegWrite(EXtoMEM_RegWrite),
    .EXtoMEM_RegDest(EXtoMEM_RegDest), .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite),
    .wb_MemtoReg(wb_MemtoReg), .wb_ReadData(wb_ReadData), .wb_ALUresult(wb_ALUresult),
    .wb_RegDest(wb_RegDest), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, fl;
    logic [31:0] alu, rt;
    logic [4:0]  rd;
    logic        z;
    logic [31:0] ba;
    logic        br, mr, mw, m2r, rw;
    logic [31:0] rdata;
    logic        e_fwd_rw, e_pcsrc, e_req, e_we, e_fault, e_wbv, e_wbrw, e_wbm2r;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    ex_valid = t.v; flush = t.fl; ALUresult = t.alu; EX_Rt = t.rt; RegDest = t.rd; zero = t.z;
    Branch_Addr = t.ba; Branch = t.br; MemRead = t.mr; MemWrite = t.mw; MemtoReg = t.m2r; RegWrite = t.rw;
  endtask

  task automatic drive_load(input logic [31:0] addr, input logic [4:0] rd);
    ex_valid = 1'b1; flush = 1'b0; ALUresult = addr; EX_Rt = '0; RegDest = rd; zero = 1'b0;
    Branch_Addr = '0; Branch = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; MemtoReg = 1'b1; RegWrite = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, wbv_cnt, stall_cnt;
    logic addr_ok;
    //             v fl alu        rt           rd z ba      br mr mw m2r rw rdata          fwd pc req we flt wbv wbrw wbm2r
    vecs[0]  = '{1, 0, 32'h10,  32'h0,        5, 0, 32'h0,  0, 0, 0, 0, 1, 32'h0,         1, 0, 0, 0, 0, 1, 1, 0};
    vecs[1]  = '{1, 0, 32'h200, 32'h12345678, 0, 0, 32'h0,  0, 0, 1, 0, 0, 32'h0,         0, 0, 1, 1, 0, 1, 0, 0};
    vecs[2]  = '{1, 0, 32'h102, 32'h0,        3, 0, 32'h0,  0, 1, 0, 1, 1, 32'h11111111,  1, 0, 0, 0, 1, 1, 0, 1};
    vecs[3]  = '{1, 0, 32'h0,   32'h0,        0, 1, 32'h40, 1, 0, 0, 0, 0, 32'h0,         0, 1, 0, 0, 0, 1, 0, 0};
    vecs[4]  = '{1, 0, 32'h4,   32'h0,        0, 0, 32'h40, 1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 1, 0, 0};
    vecs[5]  = '{1, 0, 32'h300, 32'h0,        9, 0, 32'h0,  0, 1, 0, 1, 1, 32'hCAFEF00D,  1, 0, 1, 0, 0, 1, 1, 1};
    vecs[6]  = '{1, 1, 32'h20,  32'h0,        6, 0, 32'h0,  0, 0, 0, 0, 1, 32'h0,         0, 0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{0, 0, 32'h104, 32'h0,        0, 0, 32'h0,  0, 1, 0, 1, 1, 32'h0,         0, 0, 0, 0, 0, 0, 0, 0};
    vecs[8]  = '{1, 0, 32'h208, 32'hA5A5A5A5, 0, 0, 32'h0,  0, 1, 1, 0, 0, 32'h0,         0, 0, 1, 1, 0, 1, 0, 0};
    vecs[9]  = '{1, 0, 32'h201, 32'h5,        0, 0, 32'h0,  0, 0, 1, 0, 0, 32'h0,         0, 0, 0, 0, 1, 1, 0, 0};
    vecs[10] = '{0, 0, 32'h0,   32'h0,        0, 1, 32'h80, 1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, 0, 0};
    drive(vecs[7]); ex_valid = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
    #12;
    chk("rst_req", {31'b0, dmem_req}, 0);
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_fwd", EXtoMEM_ALUresult, 0);
    chk("rst_pcbranch", PCBranch, 0);
    chk("rst_wbv", {31'b0, wb_valid}, 0);
    chk("rst_fault", {31'b0, mem_fault}, 0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vecs[i]); dmem_ready = 1'b1; dmem_rdata = vecs[i].rdata;
      @(posedge clk); #1;
      chk($sformatf("v%0d_fwd_alu", i), EXtoMEM_ALUresult, vecs[i].alu);
      chk($sformatf("v%0d_fwd_rw", i), {31'b0, EXtoMEM_RegWrite}, {31'b0, vecs[i].e_fwd_rw});
      chk($sformatf("v%0d_pcsrc", i), {31'b0, PCSrc}, {31'b0, vecs[i].e_pcsrc});
      chk($sformatf("v%0d_pcbranch", i), PCBranch, vecs[i].ba);
      chk($sformatf("v%0d_req", i), {31'b0, dmem_req}, {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d_we", i), {31'b0, dmem_we}, {31'b0, vecs[i].e_we});
      chk($sformatf("v%0d_fault", i), {31'b0, mem_fault}, {31'b0, vecs[i].e_fault});
      chk($sformatf("v%0d_stall", i), {31'b0, stall}, 0);
      if (vecs[i].e_req) chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].alu);
      if (vecs[i].e_we) chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].rt);
      ex_valid = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("v%0d_wbv", i), {31'b0, wb_valid}, {31'b0, vecs[i].e_wbv});
      chk($sformatf("v%0d_wbrw", i), {31'b0, wb_RegWrite}, {31'b0, vecs[i].e_wbrw});
      chk($sformatf("v%0d_wbm2r", i), {31'b0, wb_MemtoReg}, {31'b0, vecs[i].e_wbm2r});
      chk($sformatf("v%0d_req_clr", i), {31'b0, dmem_req}, 0);
      chk($sformatf("v%0d_fault_clr", i), {31'b0, mem_fault}, 0);
      if (vecs[i].e_wbv) begin
        chk($sformatf("v%0d_wb_alu", i), wb_ALUresult, vecs[i].alu);
        chk($sformatf("v%0d_wb_rd", i), {27'b0, wb_RegDest}, {27'b0, vecs[i].rd});
      end
      if (vecs[i].e_req && !vecs[i].e_we) chk($sformatf("v%0d_wb_rdata", i), wb_ReadData, vecs[i].rdata);
    end

    // load with three wait cycles
    @(negedge clk); drive_load(32'h100, 5'd7); dmem_ready = 1'b0; dmem_rdata = '0;
    @(posedge clk); #1; ex_valid = 1'b0;
    stall_cnt = 0; wbv_cnt = 0; addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (stall) stall_cnt++;
      if (dmem_addr !== 32'h100) addr_ok = 1'b0;
      if (wb_valid) wbv_cnt++;
      @(posedge clk); #1;
    end
    dmem_ready = 1'b1; dmem_rdata = 32'hDEADBEEF; #1;
    if (dmem_addr !== 32'h100) addr_ok = 1'b0;
    chk("ld_stall_cycles", stall_cnt, 3);
    chk("ld_addr_stable", {31'b0, addr_ok}, 1);
    chk("ld_ready_stall", {31'b0, stall}, 0);
    chk("ld_ready_req", {31'b0, dmem_req}, 1);
    @(posedge clk); #1;
    if (wb_valid) wbv_cnt++;
    chk("ld_wb_rdata", wb_ReadData, 32'hDEADBEEF);
    chk("ld_wb_m2r", {31'b0, wb_MemtoReg}, 1);
    chk("ld_wb_rw", {31'b0, wb_RegWrite}, 1);
    chk("ld_wb_rd", {27'b0, wb_RegDest}, 7);
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    if (wb_valid) wbv_cnt++;
    chk("ld_wbv_pulses", wbv_cnt, 1);

    // timeout with ready stuck low
    @(negedge clk); drive_load(32'h400, 5'd8); dmem_ready = 1'b0;
    @(posedge clk); #1; ex_valid = 1'b0;
    n = 0;
    while (stall && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    chk("to_stall_cycles", n, 63);
    chk("to_fault", {31'b0, mem_fault}, 1);
    chk("to_req_drop", {31'b0, dmem_req}, 0);
    @(posedge clk); #1;
    chk("to_fault_clr", {31'b0, mem_fault}, 0);
    chk("to_stall_clr", {31'b0, stall}, 0);
    chk("to_wbv", {31'b0, wb_valid}, 1);
    chk("to_wbrw", {31'b0, wb_RegWrite}, 0);

    // reset in the tenth stall cycle
    @(negedge clk); drive_load(32'h500, 5'd9); dmem_ready = 1'b0;
    @(posedge clk); #1; ex_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("rm_stall_before", {31'b0, stall}, 1);
    reset = 1'b1; #1;
    chk("rm_req", {31'b0, dmem_req}, 0);
    chk("rm_stall", {31'b0, stall}, 0);
    chk("rm_addr", dmem_addr, 0);
    chk("rm_fwd", EXtoMEM_ALUresult, 0);
    chk("rm_wbv", {31'b0, wb_valid}, 0);
    chk("rm_fault", {31'b0, mem_fault}, 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); drive_load(32'h600, 5'd10); dmem_ready = 1'b1; dmem_rdata = 32'h0BADF00D;
    @(posedge clk); #1; ex_valid = 1'b0;
    chk("rm_after_req", {31'b0, dmem_req}, 1);
    chk("rm_after_stall", {31'b0, stall}, 0);
    @(posedge clk); #1;
    chk("rm_after_rdata", wb_ReadData, 32'h0BADF00D);
    chk("rm_after_wbv", {31'b0, wb_valid}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage; sits directly downstream of the EX stage.
- Holds the EX/MEM pipeline register and resolves branches (PCSrc).
- Runs loads/stores on the data memory over a req/ready handshake, stalling upstream while an access is outstanding.
- Drives the MEM/WB register and the EX/MEM forwarding value consumed by EX.

Parameters:
DATA_W, 32, datapath width
REG_W, 5, register-index width (low bits of EX RegDest)
TIMEOUT, 64, max cycles waiting for dmem_ready before abort (must be >= 2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
ex_valid  in  1  EX holds a real instruction (0 = bubble)
ALUresult  in  DATA_W  EX ALU result / memory address
EX_Rt  in  DATA_W  store data (forwarded rt)
RegDest  in  REG_W  destination register
zero  in  1  ALU zero flag
Branch_Addr  in  DATA_W  computed branch target
Branch, MemRead, MemWrite, MemtoReg, RegWrite  in  1 each  control bits from ID/EX
flush  in  1  kill instruction entering EX/MEM (insert bubble)
dmem_req  out  1  memory request valid
dmem_we  out  1  1 = store
dmem_addr  out  DATA_W  word address (byte addr, [1:0]=0)
dmem_wdata  out  DATA_W  store data
dmem_ready  in  1  memory accepts/completes request this cycle
dmem_rdata  in  DATA_W  load data, valid when dmem_ready=1 on a read
stall  out  1  hold PC, IF/ID, ID/EX and EX inputs
PCSrc  out  1  take branch
PCBranch  out  DATA_W  branch target
EXtoMEM_ALUresult  out  DATA_W  forwarding value (registered ALUresult)
EXtoMEM_RegWrite, EXtoMEM_RegDest  out  1, REG_W  for forwarding unit
wb_valid, wb_RegWrite, wb_MemtoReg  out  1 each  MEM/WB control
wb_ReadData, wb_ALUresult  out  DATA_W  MEM/WB data
wb_RegDest  out  REG_W  MEM/WB destination
mem_fault  out  1  one-cycle pulse: misaligned or timed-out access

Behaviour:
- Reset: every register and output is 0. FSM state = IDLE; timeout counter = 0.
- EX/MEM register captures all EX inputs on each edge while stall=0. Capture with flush=1 or ex_valid=0 loads a bubble: valid=0, all control bits 0. stall=1 holds the register.
- PCSrc = m_valid & Branch & zero, combinational from the EX/MEM register. PCBranch = registered Branch_Addr.
- Misalignment: an op is misaligned when m_valid & (MemRead|MemWrite) & addr[1:0]!=0.
  - No request is issued.
  - mem_fault pulses.
  - The instruction passes to MEM/WB with RegWrite forced to 0.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS when the EX/MEM register holds a valid, aligned MemRead or MemWrite. In that cycle dmem_req=1 and stall = ~dmem_ready.
  - In ACCESS, dmem_req, dmem_we, dmem_addr and dmem_wdata stay stable until dmem_ready=1.
  - On dmem_ready=1 the access completes and the FSM returns to IDLE the next cycle. Zero-wait memory therefore gives 1-cycle MEM latency with no stall.
  - Timeout counter increments each cycle in ACCESS without ready. When it reaches TIMEOUT-1:
    - the access aborts and mem_fault pulses;
    - the instruction retires with RegWrite=0;
    - stall drops and the FSM returns to IDLE.
- If MemRead and MemWrite are both set, treat the op as a store.
- MEM/WB register updates on any edge with stall=0:
  - wb_ReadData = dmem_rdata, sampled at ready.
  - Remaining fields come from the EX/MEM register.
  - While stall=1, MEM/WB loads a bubble (wb_valid=0, wb_RegWrite=0) so WB never writes twice.
- stall = ACCESS-pending & ~dmem_ready, combinational. No other source asserts it.
- Reset asserted mid-access clears all state immediately. dmem_req drops asynchronously. The access is abandoned.
- Back-to-back memory ops:
  - A new op is captured on the edge where ready completes the previous one.
  - dmem_req may stay high continuously, but the address/data change only on that edge.

Decomposition:
- Shared package: mem_stage FSM state encoding (IDLE=0, ACCESS=1) and the control-bundle field order, reused by the hazard/forwarding unit.
- One sub-module, mem_wb_reg: the MEM/WB pipeline register with bubble-insert input.
- The EX/MEM register and FSM stay in mem_stage.

Test Plan:
- ALU op, ex_valid=1, ALUresult=0x0000_0010, RegDest=5, RegWrite=1 -> EXtoMEM_ALUresult=0x10 after 1 edge; wb_ALUresult=0x10 and wb_RegDest=5 after 2 edges; stall never 1.
- Load, addr 0x100, dmem_ready held 0 for 3 cycles then 1 with rdata 0xDEADBEEF:
  - stall=1 for exactly 3 cycles;
  - dmem_addr constant at 0x100;
  - wb_ReadData=0xDEADBEEF with wb_MemtoReg=1 on the next edge;
  - only one wb_valid pulse.
- Store, addr 0x200, data 0x1234_5678, ready=1 immediately -> dmem_req=1 and dmem_we=1 for 1 cycle; no stall; wb_RegWrite=0.
- Load at addr 0x102 -> dmem_req stays 0; mem_fault pulses once; wb_RegWrite=0.
- Branch=1, zero=1, Branch_Addr=0x40 -> PCSrc=1, PCBranch=0x40 one edge after capture. Repeat with zero=0 -> PCSrc=0.
- Load with dmem_ready stuck 0, TIMEOUT=64 -> stall high 63 cycles, then mem_fault pulses and stall drops. Second run asserts reset in cycle 10 of the stall -> all outputs 0 immediately; FSM in IDLE.
